out_lane_buffer: RTL and testbench
==================================

// Module: out_lane_buffer
// PURPOSE
//  Parametrised output buffer for a processing element. Results are written one lane (byte) at a time into packed
//  words, either by overwrite or by saturating accumulate. Words are read back by random access, or drained as a
//  ready/valid stream to the next layer. Replaces file-based dump/load: clearing and export are on-chip operations.
// PARAMETERS
//  LANES   4    lanes per word
//  LANE_W  8    bits per lane; signed two's complement in accumulate mode
//  DEPTH   128  words; power of two
//  ADDR_W  $clog2(DEPTH)  address width (derived; do not override)
// PORTS
//  clock        in   1               rising-edge clock
//  reset_n      in   1               asynchronous, active-low reset
//  wr_en        in   1               lane write request
//  wr_acc       in   1               1: saturating add into lane; 0: overwrite
//  wr_addr      in   ADDR_W          word address
//  wr_lane      in   $clog2(LANES)   lane select; lane 0 = MSB lane
//  wr_data      in   LANE_W          lane data
//  rd_en        in   1               random read request
//  rd_addr      in   ADDR_W          read word address
//  rd_data      out  LANES*LANE_W    read word; lane 0 in MSBs
//  rd_valid     out  1               rd_data valid (1-cycle pulse)
//  clear        in   1               start zeroing all words
//  drain_start  in   1               start stream export
//  drain_base   in   ADDR_W          first word to export
//  drain_count  in   ADDR_W+1        words to export; 0 means DEPTH
//  drain_valid  out  1               stream data valid
//  drain_ready  in   1               downstream accept
//  drain_data   out  LANES*LANE_W    stream word
//  drain_last   out  1               marks final word of a drain
//  busy         out  1               FSM not in IDLE
//  dropped      out  1               1-cycle pulse: wr_en/rd_en/command ignored because busy
// BEHAVIOUR
//  - Reset: all outputs 0; FSM enters CLEAR on reset release. Memory is not reset directly; auto-CLEAR zeroes it.
//    busy is 1 from the first clock after release until DEPTH words are zeroed.
//  - FSM states: IDLE, CLEAR, DRAIN.
//    IDLE->CLEAR on clear. IDLE->DRAIN on drain_start (clear wins if both are high).
//    CLEAR zeroes one word per cycle, address 0..DEPTH-1, then returns to IDLE.
//    DRAIN returns to IDLE on the handshake of the word carrying drain_last.
//  - Writes (IDLE only), committed at the posedge:
//    overwrite: lane <= wr_data.
//    accumulate: lane <= sat(lane + wr_data), computed signed at LANE_W+1 bits and clamped to
//    [-2^(LANE_W-1), 2^(LANE_W-1)-1].
//    Back-to-back accumulates to the same lane see the previous result; there is no hazard.
//  - Reads (IDLE only): rd_data and rd_valid register 1 cycle after rd_en.
//    Read and write to the same word in the same cycle returns the pre-write data.
//    rd_data holds its value when rd_valid is low.
//  - Drain: drain_valid rises the cycle after drain_start. Word k comes from address (drain_base+k) mod DEPTH
//    (wraps). drain_data and drain_last stay stable while drain_valid && !drain_ready.
//    Each handshake advances one word; full throughput is 1 word/cycle.
//  - While busy: wr_en, rd_en, clear and drain_start are ignored, and each such request pulses dropped.
//  - Reset asserted mid-CLEAR or mid-DRAIN aborts immediately: drain_valid=0 asynchronously, then a fresh auto-CLEAR runs.
// STRUCTURE
//  - Package out_lane_buffer_pkg: state enum (IDLE, CLEAR, DRAIN) and a saturation-limit function of LANE_W.
//  - Sub-module lane_sat_add: combinational signed saturating adder, instantiated once on the write path.
//  - Memory is a DEPTH x (LANES*LANE_W) register array with a lane-masked write.
// TESTING
//  1. Reset release -> busy=1 for 128 cycles, then 0; read of all addresses returns 32'h0.
//  2. Overwrite addr 5 lanes 0..3 with 11,22,33,44; rd_en addr 5 -> next cycle rd_data=32'h11223344, rd_valid=1.
//  3. Accumulate 8'h70 into addr 2 lane 1 twice -> lane reads 8'h7F (saturated).
//     Then accumulate 8'h80 three times -> 8'h80 (negative clamp).
//  4. drain_base=126, drain_count=4, ready toggling 1010 -> words 126,127,0,1 in order, each held while
//     stalled, drain_last only on word 1.
//  5. wr_en during DRAIN -> dropped pulses, memory unchanged; clear+drain_start same cycle -> CLEAR taken.
//  6. reset_n low mid-drain -> drain_valid drops at once; after release busy=1 for 128 cycles, memory all zero.

Source files
------------

// File: rtl/out_lane_buffer_pkg.sv
// Shared types and helpers for the output lane buffer.
package out_lane_buffer_pkg;

    // Controller states; exposed on state_dbg for observation.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Largest value representable in a signed lane of lane_w bits.
    function automatic int sat_hi(input int lane_w);
        return (1 << (lane_w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed lane of lane_w bits.
    function automatic int sat_lo(input int lane_w);
        return -(1 << (lane_w - 1));
    endfunction

endpackage

// File: rtl/out_lane_buffer_lane_sat_add.sv
// Combinational signed saturating adder for one lane.
// The sum is formed one bit wider than a lane, then clamped to the lane range.
module lane_sat_add
    import out_lane_buffer_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum
);

    localparam logic signed [LANE_W:0] HI = (LANE_W + 1)'(sat_hi(LANE_W));
    localparam logic signed [LANE_W:0] LO = (LANE_W + 1)'(sat_lo(LANE_W));

    logic signed [LANE_W:0] wide;

    // Sign-extend both operands, add, and clamp into the lane range.
    always_comb begin
        wide = $signed({a[LANE_W-1], a}) + $signed({b[LANE_W-1], b});
        if (wide > HI) begin
            sum = HI[LANE_W-1:0];
        end else if (wide < LO) begin
            sum = LO[LANE_W-1:0];
        end else begin
            sum = wide[LANE_W-1:0];
        end
    end

endmodule

// File: rtl/out_lane_buffer.sv
// Output buffer for a processing element: lane-granular overwrite or saturating
// accumulate into packed words, random-access reads, on-chip clear and a
// ready/valid drain stream.
//
// Drain handshake: a word transfers on any rising clock edge where drain_valid
// and drain_ready are both 1. While drain_valid is 1 and drain_ready is 0,
// drain_data and drain_last hold; drain_valid never drops without a transfer
// except on reset.
module out_lane_buffer
    import out_lane_buffer_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LSEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic                    wr_acc,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [LSEL_W-1:0]       wr_lane,
    input  logic [LANE_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [LANES*LANE_W-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    clear,
    input  logic                    drain_start,
    input  logic [ADDR_W-1:0]       drain_base,
    input  logic [ADDR_W:0]         drain_count,
    output logic                    drain_valid,
    input  logic                    drain_ready,
    output logic [LANES*LANE_W-1:0] drain_data,
    output logic                    drain_last,
    output logic                    busy,
    output logic                    dropped,
    output state_t                  state_dbg
);

    localparam int WORD_W = LANES * LANE_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W + 1)'(1);

    state_t state_q, state_d;
    logic   boot_q;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] drain_ptr;
    logic [ADDR_W:0]   drain_rem;
    logic [ADDR_W:0]   drain_cnt_eff;

    logic accept, wr_ok, rd_ok, clr_ok, drn_ok, any_req, drain_hs;

    logic [WORD_W-1:0] cur_word, merged_word;
    logic [LANE_W-1:0] old_lane, acc_lane, new_lane;

    // Requests are honoured only in IDLE and never in the first cycle after
    // reset release, which is reserved for launching the automatic clear.
    always_comb begin
        accept        = (state_q == IDLE) && !boot_q;
        wr_ok         = accept && wr_en;
        rd_ok         = accept && rd_en;
        clr_ok        = accept && clear;
        drn_ok        = accept && drain_start && !clear;
        any_req       = wr_en || rd_en || clear || drain_start;
        drain_hs      = (state_q == DRAIN) && drain_valid && drain_ready;
        drain_cnt_eff = (drain_count == '0) ? FULL_CNT : drain_count;
        busy          = (state_q != IDLE);
        state_dbg     = state_q;
    end

    // State register; reset parks in IDLE with boot_q forcing the auto-clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            boot_q  <= 1'b0;
        end
    end

    // Next-state logic: clear wins over drain_start when both arrive together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (boot_q || clr_ok) begin
                    state_d = CLEAR;
                end else if (drn_ok) begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (drain_hs && drain_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane-masked write path: pick the addressed lane, overwrite or accumulate,
    // and merge it back into the word. Lane 0 sits in the most significant bits.
    always_comb begin
        cur_word = mem[wr_addr];
        old_lane = '0;
        for (int l = 0; l < LANES; l++) begin
            if (wr_lane == LSEL_W'(l)) begin
                old_lane = cur_word[(LANES-1-l)*LANE_W +: LANE_W];
            end
        end
        new_lane    = wr_acc ? acc_lane : wr_data;
        merged_word = cur_word;
        for (int l = 0; l < LANES; l++) begin
            if (wr_lane == LSEL_W'(l)) begin
                merged_word[(LANES-1-l)*LANE_W +: LANE_W] = new_lane;
            end
        end
    end

    lane_sat_add #(
        .LANE_W (LANE_W)
    ) u_sat_add (
        .a   (old_lane),
        .b   (wr_data),
        .sum (acc_lane)
    );

    // Storage array: CLEAR sweeps zeros through it, otherwise accepted lane writes land.
    always_ff @(posedge clock) begin
        if (state_q == CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= merged_word;
        end
    end

    // Clear sweep address; it wraps back to 0 as the sweep finishes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_addr <= '0;
        end else if (state_q == CLEAR) begin
            clr_addr <= clr_addr + ONE_ADDR;
        end
    end

    // Random-access read port; rd_data keeps its last value between reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    // Ignored requests produce a one-cycle dropped pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dropped <= 1'b0;
        end else begin
            dropped <= any_req && !accept;
        end
    end

    // Drain stream: the output register holds the current word; each transfer
    // loads the next word from the wrapping pointer, drain_rem counts words left.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drain_valid <= 1'b0;
            drain_data  <= '0;
            drain_last  <= 1'b0;
            drain_ptr   <= '0;
            drain_rem   <= '0;
        end else if (drn_ok) begin
            drain_valid <= 1'b1;
            drain_data  <= mem[drain_base];
            drain_last  <= (drain_cnt_eff == ONE_CNT);
            drain_ptr   <= drain_base + ONE_ADDR;
            drain_rem   <= drain_cnt_eff - ONE_CNT;
        end else if (drain_hs) begin
            if (drain_last) begin
                drain_valid <= 1'b0;
                drain_last  <= 1'b0;
            end else begin
                drain_data <= mem[drain_ptr];
                drain_last <= (drain_rem == ONE_CNT);
                drain_ptr  <= drain_ptr + ONE_ADDR;
                drain_rem  <= drain_rem - ONE_CNT;
            end
        end
    end

endmodule

// File: tb/tb_out_lane_buffer.sv
// Self-checking bench for out_lane_buffer against a lane-array reference model.
module tb_out_lane_buffer;
    import out_lane_buffer_pkg::*;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int WORD_W = 32;

    logic              clock;
    logic              reset_n;
    logic              wr_en;
    logic              wr_acc;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_lane;
    logic [7:0]        wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              clear;
    logic              drain_start;
    logic [ADDR_W-1:0] drain_base;
    logic [ADDR_W:0]   drain_count;
    logic              drain_valid;
    logic              drain_ready;
    logic [WORD_W-1:0] drain_data;
    logic              drain_last;
    logic              busy;
    logic              dropped;
    state_t            state_dbg;

    int errors = 0;
    int checks = 0;

    logic [7:0]        model [DEPTH][LANES];
    logic [WORD_W-1:0] exp_q [$];

    out_lane_buffer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_acc      (wr_acc),
        .wr_addr     (wr_addr),
        .wr_lane     (wr_lane),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .clear       (clear),
        .drain_start (drain_start),
        .drain_base  (drain_base),
        .drain_count (drain_count),
        .drain_valid (drain_valid),
        .drain_ready (drain_ready),
        .drain_data  (drain_data),
        .drain_last  (drain_last),
        .busy        (busy),
        .dropped     (dropped),
        .state_dbg   (state_dbg)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    function automatic logic [WORD_W-1:0] model_word(input int a);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++) begin
            w[WORD_W-1-LANE_W*l -: LANE_W] = model[a][l];
        end
        return w;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++)
            for (int l = 0; l < LANES; l++)
                model[a][l] = 8'h00;
    endtask

    task automatic model_write(input int a, input int l, input logic [7:0] d, input logic acc);
        if (acc) model[a][l] = sat_add8(model[a][l], d);
        else     model[a][l] = d;
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_acc = 0; wr_addr = '0; wr_lane = '0; wr_data = '0;
        rd_en = 0; rd_addr = '0; clear = 0; drain_start = 0;
        drain_base = '0; drain_count = '0; drain_ready = 0;
    endtask

    task automatic do_write(input int a, input int l, input logic [7:0] d, input logic acc);
        wr_en = 1; wr_addr = ADDR_W'(a); wr_lane = 2'(l); wr_data = d; wr_acc = acc;
        model_write(a, l, d, acc);
        tick();
        wr_en = 0; wr_acc = 0;
    endtask

    task automatic do_read(input int a, output logic [WORD_W-1:0] d, output logic v);
        rd_en = 1; rd_addr = ADDR_W'(a);
        tick();
        rd_en = 0;
        d = rd_data;
        v = rd_valid;
    endtask

    // Counts cycles with busy high, starting from the current sample.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            cnt++;
            tick();
        end
    endtask

    // Runs one drain; mode 0 toggles ready 1,0,1,0..., mode 1 randomises it.
    task automatic do_drain(input int base, input int count, input int mode);
        int n;
        int got;
        logic v, l;
        logic [WORD_W-1:0] d, e;
        n = (count == 0) ? DEPTH : count;
        got = 0;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(model_word((base + k) % DEPTH));
        drain_base = ADDR_W'(base); drain_count = (ADDR_W + 1)'(count); drain_start = 1;
        tick();
        drain_start = 0;
        checks++;
        if (drain_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_valid_rise: got %b want 1", drain_valid);
        end
        for (int cyc = 0; cyc < 2000 && got < n; cyc++) begin
            drain_ready = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            v = drain_valid; d = drain_data; l = drain_last;
            tick();
            if (v && drain_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (d !== e) begin
                    errors++;
                    $display("FAIL drain_data word %0d: got %h want %h", got, d, e);
                end
                checks++;
                if (l !== (got == n - 1)) begin
                    errors++;
                    $display("FAIL drain_last word %0d: got %b want %b", got, l, (got == n - 1));
                end
                got++;
            end else begin
                checks++;
                if (drain_valid !== v || drain_data !== d || drain_last !== l) begin
                    errors++;
                    $display("FAIL drain_hold: got v%b %h l%b want v%b %h l%b",
                             drain_valid, drain_data, drain_last, v, d, l);
                end
            end
        end
        drain_ready = 0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL drain_count: got %0d words want %0d", got, n);
        end
        checks++;
        if (busy !== 1'b0 || drain_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: got busy %b valid %b want 0 0", busy, drain_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cnt;
        logic [WORD_W-1:0] d;
        logic v;
        reset_n = 0;
        idle_inputs();
        tick(); tick(); tick();
        checks++;
        if ({busy, rd_valid, drain_valid, drain_last, dropped} !== 5'b0 || rd_data !== '0 || drain_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got b%b rv%b dv%b dl%b dr%b rd %h dd %h want all 0",
                     busy, rd_valid, drain_valid, drain_last, dropped, rd_data, drain_data);
        end
        reset_n = 1;
        tick();
        checks++;
        if (busy !== 1'b1 || state_dbg !== CLEAR) begin
            errors++;
            $display("FAIL reset_autoclear: got busy %b state %0d want 1 CLEAR", busy, state_dbg);
        end
        count_busy(cnt);
        checks++;
        if (cnt != DEPTH) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d want %0d", cnt, DEPTH);
        end
        model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            do_read(a, d, v);
            checks++;
            if (v !== 1'b1 || d !== 32'h0) begin
                errors++;
                $display("FAIL reset_zero addr %0d: got v%b %h want v1 00000000", a, v, d);
            end
        end
    endtask

    task automatic test_overwrite();
        logic [WORD_W-1:0] d;
        logic v;
        do_write(5, 0, 8'h11, 0);
        do_write(5, 1, 8'h22, 0);
        do_write(5, 2, 8'h33, 0);
        do_write(5, 3, 8'h44, 0);
        do_read(5, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h11223344) begin
            errors++;
            $display("FAIL overwrite: got v%b %h want v1 11223344", v, d);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h11223344) begin
            errors++;
            $display("FAIL read_hold: got v%b %h want v0 11223344", rd_valid, rd_data);
        end
    endtask

    task automatic test_accumulate();
        logic [WORD_W-1:0] d, e;
        logic v;
        do_write(2, 1, 8'h70, 1);
        do_write(2, 1, 8'h70, 1);
        do_read(2, d, v);
        checks++;
        if (d[23:16] !== 8'h7F || d !== model_word(2)) begin
            errors++;
            $display("FAIL acc_pos_sat: got %h want lane1 7f word %h", d, model_word(2));
        end
        do_write(2, 1, 8'h80, 1);
        do_write(2, 1, 8'h80, 1);
        do_write(2, 1, 8'h80, 1);
        do_read(2, d, v);
        checks++;
        if (d[23:16] !== 8'h80 || d !== model_word(2)) begin
            errors++;
            $display("FAIL acc_neg_sat: got %h want lane1 80 word %h", d, model_word(2));
        end
        // Read and write to the same word in one cycle: read sees the old word.
        e = model_word(2);
        rd_en = 1; rd_addr = 7'd2;
        wr_en = 1; wr_addr = 7'd2; wr_lane = 2'd1; wr_data = 8'h55; wr_acc = 0;
        model_write(2, 1, 8'h55, 0);
        tick();
        rd_en = 0; wr_en = 0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL read_during_write: got v%b %h want v1 %h", rd_valid, rd_data, e);
        end
        do_read(2, d, v);
        checks++;
        if (d !== model_word(2)) begin
            errors++;
            $display("FAIL write_after_rdw: got %h want %h", d, model_word(2));
        end
    endtask

    task automatic test_drain_wrap();
        int addrs [4] = '{126, 127, 0, 1};
        for (int i = 0; i < 4; i++)
            for (int l = 0; l < LANES; l++)
                do_write(addrs[i], l, 8'($urandom_range(0, 255)), 0);
        do_drain(126, 4, 0);
    endtask

    task automatic test_busy_drop();
        int cnt;
        logic [WORD_W-1:0] d;
        logic v;
        for (int l = 0; l < LANES; l++) do_write(10, l, 8'($urandom_range(1, 255)), 0);
        drain_base = 7'd10; drain_count = 8'd3; drain_start = 1; drain_ready = 0;
        tick();
        drain_start = 0;
        wr_en = 1; wr_addr = 7'd10; wr_lane = 2'd0; wr_data = ~model[10][0]; wr_acc = 0;
        tick();
        wr_en = 0;
        checks++;
        if (dropped !== 1'b1) begin
            errors++;
            $display("FAIL drop_write: got %b want 1", dropped);
        end
        tick();
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse_len: got %b want 0", dropped);
        end
        rd_en = 1; rd_addr = 7'd10;
        tick();
        rd_en = 0;
        checks++;
        if (dropped !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_read: got dropped %b rd_valid %b want 1 0", dropped, rd_valid);
        end
        drain_ready = 1;
        for (int i = 0; i < 20 && busy; i++) tick();
        drain_ready = 0;
        do_read(10, d, v);
        checks++;
        if (d !== model_word(10)) begin
            errors++;
            $display("FAIL drop_mem_unchanged: got %h want %h", d, model_word(10));
        end
        // Simultaneous clear and drain_start: clear takes priority.
        clear = 1; drain_start = 1; drain_base = 7'd0; drain_count = 8'd1;
        tick();
        clear = 0; drain_start = 0;
        checks++;
        if (state_dbg !== CLEAR || drain_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_priority: got state %0d dv %b busy %b want CLEAR 0 1",
                     state_dbg, drain_valid, busy);
        end
        count_busy(cnt);
        checks++;
        if (cnt != DEPTH) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d want %0d", cnt, DEPTH);
        end
        model_clear();
        do_read(10, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL clear_zero: got %h want 00000000", d);
        end
    endtask

    task automatic test_reset_mid_drain();
        int cnt;
        int bad;
        logic [WORD_W-1:0] d;
        logic v;
        for (int a = 20; a < 28; a++) do_write(a, a % LANES, 8'($urandom_range(1, 255)), 0);
        drain_base = 7'd20; drain_count = 8'd8; drain_start = 1;
        tick();
        drain_start = 0; drain_ready = 1;
        tick(); tick();
        drain_ready = 0;
        checks++;
        if (drain_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_drain_valid: got %b want 1", drain_valid);
        end
        #2;
        reset_n = 0;
        #1;
        checks++;
        if (drain_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: got dv %b busy %b want 0 0", drain_valid, busy);
        end
        tick(); tick();
        reset_n = 1;
        tick();
        count_busy(cnt);
        checks++;
        if (cnt != DEPTH) begin
            errors++;
            $display("FAIL reclear_busy_len: got %0d want %0d", cnt, DEPTH);
        end
        model_clear();
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            do_read(a, d, v);
            if (v !== 1'b1 || d !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reclear_zero: got %0d nonzero words want 0", bad);
        end
    endtask

    task automatic test_random();
        logic [WORD_W-1:0] e;
        logic did_rd;
        int a, l;
        logic [7:0] dd;
        logic acc;
        for (int i = 0; i < 400; i++) begin
            did_rd = 1'($urandom_range(0, 1));
            rd_en = did_rd;
            rd_addr = 7'($urandom_range(0, 7));
            if (did_rd) exp_q.push_back(model_word(int'(rd_addr)));
            wr_en = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 7); l = $urandom_range(0, 3);
            dd = 8'($urandom_range(0, 255)); acc = 1'($urandom_range(0, 1));
            wr_addr = 7'(a); wr_lane = 2'(l); wr_data = dd; wr_acc = acc;
            if (wr_en) model_write(a, l, dd, acc);
            tick();
            checks++;
            if (did_rd) begin
                e = exp_q.pop_front();
                if (rd_valid !== 1'b1 || rd_data !== e) begin
                    errors++;
                    $display("FAIL rand_read %0d: got v%b %h want v1 %h", i, rd_valid, rd_data, e);
                end
            end else if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_noread %0d: got v%b want v0", i, rd_valid);
            end
        end
        rd_en = 0; wr_en = 0; wr_acc = 0;
        do_drain($urandom_range(120, 127), $urandom_range(5, 20), 1);
        do_drain($urandom_range(0, 127), 0, 1);
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_overwrite();
        test_accumulate();
        test_drain_wrap();
        test_busy_drop();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
